// File: rtl/regfile_param_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: one write port and
// two read ports, plus the Busy flag from the clear sequencer.
interface regfile_param_2r1w_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] D;
    logic [ADDR_WIDTH-1:0] W_ADR;
    logic                  W_en;
    logic [ADDR_WIDTH-1:0] A_ADR;
    logic [DATA_WIDTH-1:0] AD;
    logic [ADDR_WIDTH-1:0] B_ADR;
    logic [DATA_WIDTH-1:0] BD;
    logic                  Busy;

    // The switch matrix side drives addresses and write data
    modport master (
        output D, W_ADR, W_en, A_ADR, B_ADR,
        input  AD, BD, Busy
    );

    // The register file side returns read data and the Busy flag
    modport slave (
        input  D, W_ADR, W_en, A_ADR, B_ADR,
        output AD, BD, Busy
    );
endinterface

// File: rtl/regfile_param_2r1w.sv
// Parametrised 2-read/1-write register file BEL.
// After every reset a clear sequencer walks the whole array writing zeros;
// while it runs (and while reset is held) writes are ignored and reads
// return 0. Each read port has an optional write-first bypass and an
// optional output register, both selected by ConfigBits.
module regfile_param_2r1w #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 32,
    parameter int NoConfigBits =
        4
) (
    input  logic                    UserCLK,
    input  logic                    UserRST_n,
    input  logic [NoConfigBits-1:0] ConfigBits,
    regfile_param_2r1w_if.slave     bus
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] clr_addr_next;

    logic                  busy;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    logic                  a_valid;
    logic                  b_valid;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] a_raw;
    logic [DATA_WIDTH-1:0] b_raw;
    logic [DATA_WIDTH-1:0] ad_reg;
    logic [DATA_WIDTH-1:0] bd_reg;

    logic cfg_a_reg;
    logic cfg_b_reg;
    logic cfg_a_byp;
    logic cfg_b_byp;

    assign cfg_a_reg = ConfigBits[0];
    assign cfg_b_reg = ConfigBits[1];
    assign cfg_a_byp = ConfigBits[2];
    assign cfg_b_byp = ConfigBits[3];

    assign busy    = (state == CLEAR);
    assign a_valid = ({1'b0, bus.A_ADR} < DEPTH_EXT);
    assign b_valid = ({1'b0, bus.B_ADR} < DEPTH_EXT);
    assign w_valid = ({1'b0, bus.W_ADR} < DEPTH_EXT);

    // Sequencer state register; reset restarts the clear walk at entry 0
    always_ff @(posedge UserCLK) begin
        if (!UserRST_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Clear walk advances one entry per edge and hands over to RUN after the last one
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        if (state == CLEAR) begin
            clr_addr_next = clr_addr + 1'b1;
            if (clr_addr == LAST_ADR) begin
                state_next = RUN;
            end
        end
    end

    // Single write port shared by the clear sequencer and the user
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.W_ADR;
        mem_wd = bus.D;
        if (busy) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end else if (bus.W_en && w_valid) begin
            mem_we = 1'b1;
        end
    end

    // Array update; nothing is written while reset is held
    always_ff @(posedge UserCLK) begin
        if (UserRST_n && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Raw read values: zero while busy or out of range, optional write-first forwarding
    always_comb begin
        a_raw = '0;
        b_raw = '0;
        if (!busy && a_valid) begin
            if (cfg_a_byp && bus.W_en && (bus.W_ADR == bus.A_ADR)) begin
                a_raw = bus.D;
            end else begin
                a_raw = mem[bus.A_ADR];
            end
        end
        if (!busy && b_valid) begin
            if (cfg_b_byp && bus.W_en && (bus.W_ADR == bus.B_ADR)) begin
                b_raw = bus.D;
            end else begin
                b_raw = mem[bus.B_ADR];
            end
        end
    end

    // Output registers capture the raw read values every edge
    always_ff @(posedge UserCLK) begin
        if (!UserRST_n) begin
            ad_reg <= '0;
            bd_reg <= '0;
        end else begin
            ad_reg <= a_raw;
            bd_reg <= b_raw;
        end
    end

    assign bus.AD   = cfg_a_reg ? ad_reg : a_raw;
    assign bus.BD   = cfg_b_reg ? bd_reg : b_raw;
    assign bus.Busy = busy;

endmodule
